mdio_arb: RTL and testbench

Round-robin arbiter that shares the single MDIO register-access port of the PHY configuration block among NREQ independent requesters (host command decoder, link monitor, diagnostics). It latches each requester's read/write, serialises them one at a time onto the PHY block's request/busy handshake, returns read data with a per-requester completion pulse, and holds off new grants while PHY initialisation runs. Runs in the 2.5 MHz MDIO clock domain alongside the PHY configuration block.

---
 rtl/mdio_arb_pkg.sv | 22 ++
 rtl/mdio_arb_if.sv | 38 +++
 rtl/mdio_arb_rr_arbiter.sv | 35 +++
 rtl/mdio_arb.sv | 191 +++++++++++++++++++
 tb/tb_mdio_arb.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_arb_pkg.sv
// mdio_arb_pkg
// Shared definitions for the MDIO access arbiter:
//   - state_t        : arbiter FSM states
//   - MDIO_REG_W     : PHY register address width
//   - MDIO_DATA_W    : PHY register data width
//   - TIMEOUT_RDATA  : read data returned when a read transaction times out
package mdio_arb_pkg;

  localparam int MDIO_REG_W  = 8;
  localparam int MDIO_DATA_W = 16;

  localparam logic [MDIO_DATA_W-1:0] TIMEOUT_RDATA = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mdio_arb_if.sv
// mdio_arb_if
// Request/busy handshake between the arbiter and the PHY configuration block.
//   mdio_rd_request : one-cycle read pulse toward the PHY block
//   mdio_wr_request : one-cycle write pulse toward the PHY block
//   mdio_register   : register address, stable for the whole transaction
//   mdio_wr_data    : write data, stable for the whole transaction
//   mdio_rw_busy    : PHY block busy, rises after a request, falls on completion
//   mdio_rd_data    : read result, valid when mdio_rw_busy falls
// Modports: master = arbiter side, slave = PHY block side.
interface mdio_arb_if;
  import mdio_arb_pkg::*;

  logic                   mdio_rd_request;
  logic                   mdio_wr_request;
  logic [MDIO_REG_W-1:0]  mdio_register;
  logic [MDIO_DATA_W-1:0] mdio_wr_data;
  logic                   mdio_rw_busy;
  logic [MDIO_DATA_W-1:0] mdio_rd_data;

  modport master (
    output mdio_rd_request,
    output mdio_wr_request,
    output mdio_register,
    output mdio_wr_data,
    input  mdio_rw_busy,
    input  mdio_rd_data
  );

  modport slave (
    input  mdio_rd_request,
    input  mdio_wr_request,
    input  mdio_register,
    input  mdio_wr_data,
    output mdio_rw_busy,
    output mdio_rd_data
  );

endinterface

// File: rtl/mdio_arb_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin grant. Searches upward from (last_grant+1) mod
// NREQ, wrapping, and returns the first pending index.
//   pend        : pending request vector
//   last_grant  : index granted most recently
//   grant_valid : at least one request pending
//   grant_idx   : selected requester (meaningful only when grant_valid=1)
module rr_arbiter #(
  parameter  int NREQ  = 3,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  pend,
  input  logic [IDX_W-1:0] last_grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending index
  // (lowest offset after last_grant) is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last_grant) + k) % NREQ);
      if (pend[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mdio_arb.sv
// mdio_arb
// Round-robin arbiter sharing the PHY configuration block's single MDIO
// register-access port among NREQ requesters. One transaction is in flight
// at a time; new grants are held off while PHY initialisation runs.
//   clock, reset_n : management clock, asynchronous active-low reset
//   req_rd/req_wr  : per-requester level requests (write wins if both set)
//   req_reg        : per-requester register address slices
//   req_wdata      : per-requester write data slices
//   req_ack        : one-cycle accept pulse per requester
//   req_done       : one-cycle completion pulse per requester
//   req_rdata      : read data, valid with req_done, held until next read done
//   req_err        : timeout flag, valid with req_done
//   mdio           : handshake to the PHY block (master side)
//   init_busy      : PHY initialisation in progress, blocks new grants
module mdio_arb
  import mdio_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 4095
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req_rd,
  input  logic [NREQ-1:0]             req_wr,
  input  logic [NREQ*MDIO_REG_W-1:0]  req_reg,
  input  logic [NREQ*MDIO_DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]             req_ack,
  output logic [NREQ-1:0]             req_done,
  output logic [MDIO_DATA_W-1:0]      req_rdata,
  output logic                        req_err,
  mdio_arb_if.master                  mdio,
  input  logic                        init_busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t state_reg, state_next;

  logic [IDX_W-1:0]       last_grant_reg, last_grant_next;
  logic                   op_wr_reg, op_wr_next;
  logic [MDIO_REG_W-1:0]  addr_reg, addr_next;
  logic [MDIO_DATA_W-1:0] wdata_reg, wdata_next;
  logic [MDIO_DATA_W-1:0] rdata_reg, rdata_next;
  logic                   timed_out_reg, timed_out_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [NREQ-1:0]        ack_reg, ack_next;
  logic [NREQ-1:0]        done_reg, done_next;
  logic                   err_reg, err_next;
  logic                   rd_req_reg, rd_req_next;
  logic                   wr_req_reg, wr_req_next;

  logic [NREQ-1:0]        pend;
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;
  logic                   timeout_hit;

  logic [MDIO_REG_W-1:0]  reg_slice   [NREQ];
  logic [MDIO_DATA_W-1:0] wdata_slice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign reg_slice[gi]   = req_reg[gi*MDIO_REG_W +: MDIO_REG_W];
    assign wdata_slice[gi] = req_wdata[gi*MDIO_DATA_W +: MDIO_DATA_W];
  end

  assign pend        = req_rd | req_wr;
  assign timeout_hit = (cnt_reg >= CNT_W'(TIMEOUT));

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .pend        (pend),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    op_wr_next      = op_wr_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;
    timed_out_next  = timed_out_reg;
    cnt_next        = cnt_reg;
    ack_next        = '0;
    done_next       = '0;
    err_next        = 1'b0;
    rd_req_next     = 1'b0;
    wr_req_next     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (!init_busy && grant_valid) begin
          last_grant_next     = grant_idx;
          op_wr_next          = req_wr[grant_idx];
          addr_next           = reg_slice[grant_idx];
          wdata_next          = wdata_slice[grant_idx];
          timed_out_next      = 1'b0;
          ack_next[grant_idx] = 1'b1;
          state_next          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_req_next = !op_wr_reg;
        wr_req_next = op_wr_reg;
        cnt_next    = '0;
        state_next  = ST_WAIT_BUSY;
      end
      // The timeout check takes priority so a late busy edge cannot push
      // the counter past the limit.
      ST_WAIT_BUSY: begin
        if (timeout_hit) begin
          timed_out_next = 1'b1;
          if (!op_wr_reg) rdata_next = TIMEOUT_RDATA;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (mdio.mdio_rw_busy) state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (timeout_hit) begin
          timed_out_next = 1'b1;
          if (!op_wr_reg) rdata_next = TIMEOUT_RDATA;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (!mdio.mdio_rw_busy) begin
            if (!op_wr_reg) rdata_next = mdio.mdio_rd_data;
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_next[last_grant_reg] = 1'b1;
        err_next                  = timed_out_reg;
        state_next                = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_reg <= IDX_W'(NREQ - 1);
      op_wr_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      timed_out_reg  <= 1'b0;
      cnt_reg        <= '0;
      ack_reg        <= '0;
      done_reg       <= '0;
      err_reg        <= 1'b0;
      rd_req_reg     <= 1'b0;
      wr_req_reg     <= 1'b0;
    end else begin
      last_grant_reg <= last_grant_next;
      op_wr_reg      <= op_wr_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
      timed_out_reg  <= timed_out_next;
      cnt_reg        <= cnt_next;
      ack_reg        <= ack_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      rd_req_reg     <= rd_req_next;
      wr_req_reg     <= wr_req_next;
    end
  end

  assign req_ack   = ack_reg;
  assign req_done  = done_reg;
  assign req_rdata = rdata_reg;
  assign req_err   = err_reg;

  assign mdio.mdio_rd_request = rd_req_reg;
  assign mdio.mdio_wr_request = wr_req_reg;
  assign mdio.mdio_register   = addr_reg;
  assign mdio.mdio_wr_data    = wdata_reg;

endmodule

// File: tb/tb_mdio_arb.sv
// tb_mdio_arb
// Directed bench for mdio_arb with a small PHY block model: busy rises one
// cycle after a request pulse, stays high phy_busy_len cycles, then falls
// with phy_rdata on mdio_rd_data. phy_dead makes the model ignore requests.
module tb_mdio_arb;
  import mdio_arb_pkg::*;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 4095;

  logic                        clock = 1'b0;
  logic                        reset_n;
  logic [NREQ-1:0]             req_rd, req_wr, req_ack, req_done;
  logic [NREQ*MDIO_REG_W-1:0]  req_reg;
  logic [NREQ*MDIO_DATA_W-1:0] req_wdata;
  logic [MDIO_DATA_W-1:0]      req_rdata;
  logic                        req_err;
  logic                        init_busy;

  logic                   phy_dead     = 1'b0;
  int                     phy_busy_len = 64;
  logic [MDIO_DATA_W-1:0] phy_rdata    = '0;
  logic                   phy_active;

  int n_checks = 0;
  int n_pass   = 0;

  mdio_arb_if mdio ();

  mdio_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .req_done  (req_done),
    .req_rdata (req_rdata),
    .req_err   (req_err),
    .mdio      (mdio),
    .init_busy (init_busy)
  );

  always #5 clock = ~clock;

  // PHY block model
  initial begin
    mdio.mdio_rw_busy = 1'b0;
    mdio.mdio_rd_data = '0;
    phy_active        = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if ((mdio.mdio_rd_request || mdio.mdio_wr_request) && !phy_dead) begin
        phy_active = 1'b1;
        @(posedge clock);
        #1;
        mdio.mdio_rw_busy = 1'b1;
        repeat (phy_busy_len) @(posedge clock);
        #1;
        mdio.mdio_rw_busy = 1'b0;
        mdio.mdio_rd_data = phy_rdata;
        phy_active        = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(input int limit, output logic [NREQ-1:0] seen, output int cycles);
    seen   = '0;
    cycles = 0;
    while (seen == '0 && cycles < limit) begin
      tick();
      cycles++;
      seen = req_ack;
    end
  endtask

  task automatic wait_done(input int limit, output logic [NREQ-1:0] seen, output int cycles);
    seen   = '0;
    cycles = 0;
    while (seen == '0 && cycles < limit) begin
      tick();
      cycles++;
      seen = req_done;
    end
  endtask

  initial begin
    logic [NREQ-1:0] seen;
    logic [NREQ-1:0] acc;
    int              cyc;

    reset_n   = 1'b0;
    req_rd    = '0;
    req_wr    = '0;
    req_reg   = '0;
    req_wdata = '0;
    init_busy = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_ack", req_ack, 0);
    chk("rst_done", req_done, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_err", req_err, 0);
    chk("rst_rdreq", mdio.mdio_rd_request, 0);
    chk("rst_wrreq", mdio.mdio_wr_request, 0);
    reset_n = 1'b1;
    tick();

    // Single read from requester 0
    req_reg[7:0] = 8'h11;
    req_rd       = 3'b001;
    phy_rdata    = 16'hAC00;
    phy_busy_len = 64;
    tick();
    chk("rd_ack", req_ack, 3'b001);
    req_rd = '0;
    tick();
    chk("rd_ack_pulse", req_ack, 0);
    chk("rd_rdreq", mdio.mdio_rd_request, 1);
    chk("rd_wrreq", mdio.mdio_wr_request, 0);
    chk("rd_reg", mdio.mdio_register, 8'h11);
    wait_done(200, seen, cyc);
    chk("rd_done", seen, 3'b001);
    chk("rd_latency", cyc, 67);
    chk("rd_rdata", req_rdata, 16'hAC00);
    chk("rd_err", req_err, 0);
    tick();
    chk("rd_done_pulse", req_done, 0);

    // Round robin after a fresh reset: order 0,1,2,0,1,2
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    req_reg      = {8'h22, 8'h21, 8'h20};
    phy_busy_len = 3;
    req_rd       = 3'b111;
    for (int t = 0; t < 6; t++) begin
      wait_ack(20, seen, cyc);
      chk($sformatf("rr_grant%0d", t), seen, 1 << (t % 3));
      req_rd = req_rd & ~seen;
      tick();
      req_rd = 3'b111;
      chk($sformatf("rr_reg%0d", t), mdio.mdio_register, 8'h20 + t % 3);
      wait_done(50, seen, cyc);
      chk($sformatf("rr_done%0d", t), seen, 1 << (t % 3));
    end
    req_rd = '0;
    tick();

    // init_busy gating, and init_busy rising mid-transaction
    init_busy         = 1'b1;
    req_reg[15:8]     = 8'h05;
    req_wdata[31:16]  = 16'h1234;
    req_wr            = 3'b010;
    acc               = '0;
    repeat (5) begin
      tick();
      acc |= req_ack;
    end
    chk("init_block", acc, 0);
    init_busy = 1'b0;
    tick();
    chk("init_ack", req_ack, 3'b010);
    req_wr = '0;
    tick();
    chk("init_wrreq", mdio.mdio_wr_request, 1);
    chk("init_wdata", mdio.mdio_wr_data, 16'h1234);
    init_busy = 1'b1;
    wait_done(50, seen, cyc);
    chk("init_midop_done", seen, 3'b010);
    chk("init_midop_err", req_err, 0);
    req_rd = 3'b001;
    acc    = '0;
    repeat (3) begin
      tick();
      acc |= req_ack;
    end
    chk("init_block2", acc, 0);
    init_busy = 1'b0;
    tick();
    chk("init_ack2", req_ack, 3'b001);
    req_rd = '0;
    wait_done(50, seen, cyc);
    chk("init_done2", seen, 3'b001);

    // Timeout: model never raises busy
    phy_dead     = 1'b1;
    req_reg[7:0] = 8'h33;
    req_rd       = 3'b001;
    tick();
    chk("to_ack", req_ack, 3'b001);
    req_rd = '0;
    tick();
    chk("to_rdreq", mdio.mdio_rd_request, 1);
    wait_done(TIMEOUT + 100, seen, cyc);
    chk("to_done", seen, 3'b001);
    chk("to_latency", cyc, TIMEOUT + 2);
    chk("to_err", req_err, 1);
    chk("to_rdata", req_rdata, 16'hFFFF);
    phy_dead       = 1'b0;
    req_reg[23:16] = 8'h44;
    phy_rdata      = 16'h5A5A;
    req_rd         = 3'b100;
    tick();
    chk("post_to_ack", req_ack, 3'b100);
    req_rd = '0;
    wait_done(50, seen, cyc);
    chk("post_to_done", seen, 3'b100);
    chk("post_to_err", req_err, 0);
    chk("post_to_rdata", req_rdata, 16'h5A5A);

    // Write from requester 2, then rd+wr conflict from requester 1
    req_reg[23:16]   = 8'h00;
    req_wdata[47:32] = 16'h9140;
    req_wr           = 3'b100;
    tick();
    chk("wr_ack", req_ack, 3'b100);
    req_wr = '0;
    tick();
    chk("wr_wrreq", mdio.mdio_wr_request, 1);
    chk("wr_rdreq", mdio.mdio_rd_request, 0);
    chk("wr_wdata", mdio.mdio_wr_data, 16'h9140);
    chk("wr_reg", mdio.mdio_register, 8'h00);
    wait_done(50, seen, cyc);
    chk("wr_done", seen, 3'b100);
    chk("wr_rdata_kept", req_rdata, 16'h5A5A);
    req_reg[15:8]    = 8'h09;
    req_wdata[31:16] = 16'h0BEE;
    phy_rdata        = 16'h7777;
    req_rd           = 3'b010;
    req_wr           = 3'b010;
    tick();
    chk("cf_ack", req_ack, 3'b010);
    req_rd = '0;
    req_wr = '0;
    tick();
    chk("cf_wrreq", mdio.mdio_wr_request, 1);
    chk("cf_rdreq", mdio.mdio_rd_request, 0);
    chk("cf_wdata", mdio.mdio_wr_data, 16'h0BEE);
    wait_done(50, seen, cyc);
    chk("cf_done", seen, 3'b010);
    chk("cf_rdata_kept", req_rdata, 16'h5A5A);
    chk("cf_err", req_err, 0);

    // Reset during WAIT_DONE
    phy_busy_len  = 64;
    req_reg[15:8] = 8'h55;
    req_rd        = 3'b010;
    tick();
    chk("ro_ack", req_ack, 3'b010);
    req_rd = '0;
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    chk("ro_ack0", req_ack, 0);
    chk("ro_done0", req_done, 0);
    chk("ro_err0", req_err, 0);
    chk("ro_rdata0", req_rdata, 0);
    chk("ro_rdreq0", mdio.mdio_rd_request, 0);
    chk("ro_reg0", mdio.mdio_register, 0);
    chk("ro_wdata0", mdio.mdio_wr_data, 0);
    tick();
    tick();
    reset_n = 1'b1;
    acc     = '0;
    cyc     = 0;
    while (phy_active && cyc < 200) begin
      tick();
      acc |= req_done;
      cyc++;
    end
    chk("ro_no_done", acc, 0);
    chk("ro_phy_quiet", phy_active, 0);
    tick();
    req_reg[7:0] = 8'h66;
    req_rd       = 3'b101;
    tick();
    chk("ro_first_grant", req_ack, 3'b001);
    req_rd = '0;
    tick();
    chk("ro_reg", mdio.mdio_register, 8'h66);
    wait_done(200, seen, cyc);
    chk("ro_done", seen, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
